bsg_adder_cin_serial: RTL and testbench



---
 rtl/bsg_adder_cin_serial.sv | 88 ++++++++
 tb/tb_bsg_adder_cin_serial.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_adder_cin_serial.sv
// rtl/bsg_adder_cin_serial.sv - serial multi-limb add-with-carry sequencer sharing one width_p+1 adder
module bsg_adder_cin_serial #(
    parameter int width_p = 16,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [width_p*els_p-1:0]   a_i,
    input  logic [width_p*els_p-1:0]   b_i,
    input  logic                       cin_i,
    output logic                       v_o,
    output logic [width_p*els_p-1:0]   o,
    output logic                       cout_o,
    input  logic                       yumi_i
);

    localparam int ctr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ctr_w_lp-1:0] last_ctr_lp = ctr_w_lp'(els_p - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e                             state_r;
    logic [ctr_w_lp-1:0]                ctr_r;
    logic                               carry_r;
    logic                               cout_r;
    logic [els_p-1:0][width_p-1:0]      a_r;
    logic [els_p-1:0][width_p-1:0]      b_r;
    logic [els_p-1:0][width_p-1:0]      o_r;
    logic [width_p:0]                   sum;

    // The one shared adder: the counter picks which limb feeds it this cycle.
    assign sum = {1'b0, a_r[ctr_r]} + {1'b0, b_r[ctr_r]} + {{width_p{1'b0}}, carry_r};

    assign ready_o = (state_r == IDLE) & ~reset_i;
    assign v_o     = (state_r == DONE);
    assign o       = o_r;
    assign cout_o  = cout_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            ctr_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            o_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (v_i) begin
                        a_r     <= a_i;
                        b_r     <= b_i;
                        carry_r <= cin_i;
                        ctr_r   <= '0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    o_r[ctr_r] <= sum[width_p-1:0];
                    carry_r    <= sum[width_p];
                    if (ctr_r == last_ctr_lp) begin
                        cout_r  <= sum[width_p];
                        state_r <= DONE;
                    end else begin
                        ctr_r <= ctr_r + ctr_w_lp'(1);
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Consumer may only take a result that is actually on offer.
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_adder_cin_serial.sv
// tb/tb_bsg_adder_cin_serial.sv - randomized self-checking bench for bsg_adder_cin_serial
module tb_bsg_adder_cin_serial;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i, ready_o, cin_i, v_o, cout_o, yumi_i;
    logic [63:0] a_i, b_i, o;

    logic        v1_i, ready1_o, cin1_i, v1_o, cout1_o, yumi1_i;
    logic [15:0] a1_i, b1_i, o1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bsg_adder_cin_serial #(.width_p(16), .els_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .v_o(v_o), .o(o),
        .cout_o(cout_o), .yumi_i(yumi_i)
    );

    bsg_adder_cin_serial #(.width_p(16), .els_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v1_i), .ready_o(ready1_o),
        .a_i(a1_i), .b_i(b1_i), .cin_i(cin1_i), .v_o(v1_o), .o(o1),
        .cout_o(cout1_o), .yumi_i(yumi1_i)
    );

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {64'd0, c};
    endfunction

    // Present operands, check latency and result, then consume it.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [64:0] exp;
        int n;
        exp = ref_sum(a, b, c);
        chk({tag, "_ready"}, 65'(ready_o), 65'd1);
        v_i = 1'b1; a_i = a; b_i = b; cin_i = c;
        tick();
        v_i = 1'b0; a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; cin_i = 1'($urandom);
        n = 0;
        while (!v_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 65'(n), 65'd4);
        chk({tag, "_sum"}, {cout_o, o}, exp);
        if (v_o) begin
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
            chk({tag, "_ready_after_yumi"}, 65'(ready_o), 65'd1);
        end
    endtask

    initial begin
        logic [64:0] exp;
        logic [64:0] q[$];
        int acc, done, last, guard;

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; cin_i = 1'b0; a_i = '0; b_i = '0;
        v1_i = 1'b0; yumi1_i = 1'b0; cin1_i = 1'b0; a1_i = '0; b1_i = '0;
        tick();
        chk("ready_in_reset", 65'(ready_o), 65'd0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("reset_v_o", 65'(v_o), 65'd0);
        chk("reset_sum", {cout_o, o}, 65'd0);
        chk("reset_ready", 65'(ready_o), 65'd1);

        do_op("ripple16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        do_op("ripple_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        do_op("top_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

        // Backpressure: hold the result while new operands are offered.
        do_op("bp_pre", 64'h1, 64'h2, 1'b0);
        v_i = 1'b1; a_i = 64'hDEAD_BEEF_0000_FFFF; b_i = 64'h0123_4567_89AB_CDEF; cin_i = 1'b1;
        exp = ref_sum(a_i, b_i, cin_i);
        tick();
        v_i = 1'b0;
        for (int i = 0; i < 6 && !v_o; i++) tick();
        v_i = 1'b1; a_i = 64'h5555_5555_5555_5555; b_i = 64'hAAAA_AAAA_AAAA_AAAB; cin_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_v_o", 65'(v_o), 65'd1);
            chk("bp_ready", 65'(ready_o), 65'd0);
            chk("bp_hold", {cout_o, o}, exp);
            tick();
        end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk("bp_ready_after_yumi", 65'(ready_o), 65'd1);
        exp = ref_sum(a_i, b_i, cin_i);
        tick();
        v_i = 1'b0;
        for (int i = 0; i < 6 && !v_o; i++) tick();
        chk("bp_next_sum", {cout_o, o}, exp);
        if (v_o) begin
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
        end

        // Reset in the second BUSY cycle.
        v_i = 1'b1; a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; cin_i = 1'b1;
        tick();
        v_i = 1'b0;
        tick();
        reset_i = 1'b1;
        #1;
        chk("midreset_ready", 65'(ready_o), 65'd0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("midreset_v_o", 65'(v_o), 65'd0);
        chk("midreset_sum", {cout_o, o}, 65'd0);
        chk("midreset_ready_after", 65'(ready_o), 65'd1);
        do_op("after_reset", 64'h1234, 64'h1, 1'b0);

        // Throughput: v_i held, yumi whenever a result is offered.
        acc = 0; done = 0; last = -1; guard = 0;
        a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; cin_i = 1'($urandom);
        while (done < 1000 && guard < 20000) begin
            v_i = (acc < 1000);
            if (v_o) begin
                if (q.size() == 0) chk("tp_unexpected_result", 65'(v_o), 65'd0);
                else chk("tp_sum", {cout_o, o}, q.pop_front());
                yumi_i = 1'b1;
                done++;
            end else begin
                yumi_i = 1'b0;
            end
            if (ready_o && v_i) begin
                q.push_back(ref_sum(a_i, b_i, cin_i));
                if (last >= 0) chk("tp_spacing", 65'(cyc - last), 65'd6);
                last = cyc;
                acc++;
            end
            tick();
            guard++;
            a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; cin_i = 1'($urandom);
        end
        yumi_i = 1'b0; v_i = 1'b0;
        chk("tp_completed", 65'(done), 65'd1000);

        // Single-limb instance.
        chk("el1_ready", 65'(ready1_o), 65'd1);
        v1_i = 1'b1; a1_i = 16'hFFFF; b1_i = 16'h0001; cin1_i = 1'b1;
        tick();
        v1_i = 1'b0; a1_i = 16'h0; b1_i = 16'h0;
        chk("el1_busy_v_o", 65'(v1_o), 65'd0);
        tick();
        chk("el1_v_o", 65'(v1_o), 65'd1);
        chk("el1_sum", {48'd0, cout1_o, o1}, {48'd0, 17'h1_0001});
        if (v1_o) begin
            yumi1_i = 1'b1;
            tick();
            yumi1_i = 1'b0;
        end
        chk("el1_ready_after", 65'(ready1_o), 65'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
